// File: rtl/id_stage_piped_if.sv
// rtl/id_stage_piped_if.sv - fetch-side and execute-side handshake bundle of the decode stage
// slave modport faces the decode stage; master modport faces fetch/execute.
interface id_stage_piped_if #(
  parameter int WIDTH = 32,
  parameter int RA    = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instruccion;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_register1;
  logic [WIDTH-1:0] o_register2;
  logic [WIDTH-1:0] o_constante;
  logic [RA-1:0]    o_rs1;
  logic [RA-1:0]    o_rs2;
  logic [RA-1:0]    o_WriteReg;
  logic             o_RegWrite;
  logic             o_ALUSrc;
  logic             o_MemWrite;
  logic             o_MemRead;
  logic             o_Branch;
  logic             o_MemToReg;
  logic             o_SLTc;
  logic             o_illegal;
  logic [2:0]       o_ALUControl;
  logic [1:0]       o_BranchOp;

  modport slave (
    input  i_valid, i_instruccion, i_ready,
    output o_ready, o_valid, o_register1, o_register2, o_constante,
           o_rs1, o_rs2, o_WriteReg, o_RegWrite, o_ALUSrc, o_MemWrite,
           o_MemRead, o_Branch, o_MemToReg, o_SLTc, o_illegal,
           o_ALUControl, o_BranchOp
  );

  modport master (
    output i_valid, i_instruccion, i_ready,
    input  o_ready, o_valid, o_register1, o_register2, o_constante,
           o_rs1, o_rs2, o_WriteReg, o_RegWrite, o_ALUSrc, o_MemWrite,
           o_MemRead, o_Branch, o_MemToReg, o_SLTc, o_illegal,
           o_ALUControl, o_BranchOp
  );
endinterface

// File: rtl/id_stage_piped.sv
// rtl/id_stage_piped.sv - RV32I decode stage with register file, load-use stall and ID/EX register
// Optional ID_WB_BYPASS_EN: writeback data is written through into the captured operands.
module id_stage_piped #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int RA    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_RegWrite,
  input  logic [RA-1:0]    i_WriteReg,
  input  logic [WIDTH-1:0] i_WriteData,
  id_stage_piped_if.slave  bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RA-1:0]    rs1;
    logic [RA-1:0]    rs2;
    logic [RA-1:0]    rd;
    logic             reg_write;
    logic             alu_src;
    logic             mem_write;
    logic             mem_read;
    logic             branch;
    logic             mem_to_reg;
    logic             slt;
    logic             illegal;
    logic [2:0]       alu_ctl;
    logic [1:0]       br_op;
  } idex_t;

  logic [WIDTH-1:0] rf_q [NREGS];
  idex_t            idex_q, idex_d, dec;

  logic [31:0]      inst;
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic             f7b5;
  logic [RA-1:0]    rs1, rs2, rd;
  logic [WIDTH-1:0] op1, op2;
  logic             uses_rs2, haz, adv, ready;

  assign inst   = bus.i_instruccion;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7b5   = inst[30];
  assign rs1    = inst[15 +: RA];
  assign rs2    = inst[20 +: RA];
  assign rd     = inst[7 +: RA];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (i_RegWrite && i_WriteReg != '0) begin
      rf_q[i_WriteReg] <= i_WriteData;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign op1 = (i_RegWrite && i_WriteReg != '0 && i_WriteReg == rs1) ? i_WriteData : rf_q[rs1];
  assign op2 = (i_RegWrite && i_WriteReg != '0 && i_WriteReg == rs2) ? i_WriteData : rf_q[rs2];
`else
  assign op1 = rf_q[rs1];
  assign op2 = rf_q[rs2];
`endif

  // SUB from funct3=000 only for R-type; SLT/SLTU reuse the subtractor with the SLT flag.
  function automatic logic [2:0] alu_sel(input logic [2:0] fn3, input logic alt, input logic is_r);
    case (fn3)
      3'b000:  alu_sel = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010,
      3'b011:  alu_sel = ALU_SUB;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd1   = op1;
    dec.rd2   = op2;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.rd    = rd;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctl   = alu_sel(f3, f7b5, 1'b1);
        dec.slt       = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctl   = alu_sel(f3, f7b5, 1'b0);
        dec.slt       = (f3 == 3'b010) || (f3 == 3'b011);
        dec.imm       = {{(WIDTH-12){inst[31]}}, inst[31:20]};
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_ctl    = ALU_ADD;
        dec.imm        = {{(WIDTH-12){inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_ctl   = ALU_ADD;
        dec.imm       = {{(WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_ctl = ALU_SUB;
        dec.br_op   = {f3[2], f3[0]};
        dec.imm     = {{(WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign haz   = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
                 ((idex_q.rd == rs1) || ((idex_q.rd == rs2) && uses_rs2));
  assign adv   = !idex_q.valid || bus.i_ready;
  assign ready = i_rst_n && !haz && adv;

  // Flush overrides the stall so a taken branch never waits on execute.
  always_comb begin
    idex_d = idex_q;
    if (i_flush) begin
      idex_d.valid = 1'b0;
    end else if (adv) begin
      if (haz)                       idex_d = '0;
      else if (bus.i_valid && ready) idex_d = dec;
      else                           idex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) idex_q <= '0;
    else          idex_q <= idex_d;
  end

  assign bus.o_ready      = ready;
  assign bus.o_valid      = idex_q.valid;
  assign bus.o_register1  = idex_q.rd1;
  assign bus.o_register2  = idex_q.rd2;
  assign bus.o_constante  = idex_q.imm;
  assign bus.o_rs1        = idex_q.rs1;
  assign bus.o_rs2        = idex_q.rs2;
  assign bus.o_WriteReg   = idex_q.rd;
  assign bus.o_RegWrite   = idex_q.reg_write;
  assign bus.o_ALUSrc     = idex_q.alu_src;
  assign bus.o_MemWrite   = idex_q.mem_write;
  assign bus.o_MemRead    = idex_q.mem_read;
  assign bus.o_Branch     = idex_q.branch;
  assign bus.o_MemToReg   = idex_q.mem_to_reg;
  assign bus.o_SLTc       = idex_q.slt;
  assign bus.o_illegal    = idex_q.illegal;
  assign bus.o_ALUControl = idex_q.alu_ctl;
  assign bus.o_BranchOp   = idex_q.br_op;
endmodule

// File: tb/tb_id_stage_piped.sv
// tb/tb_id_stage_piped.sv - directed bench for id_stage_piped with an instruction-level reference model
module tb_id_stage_piped;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  int          errors = 0;
  int          checks = 0;
  bit          started = 1'b0;

  id_stage_piped_if #(.WIDTH(32), .RA(5)) bus ();

  id_stage_piped #(.WIDTH(32), .NREGS(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_RegWrite  (wb_en),
    .i_WriteReg  (wb_addr),
    .i_WriteData (wb_data),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, alusrc, memw, memr, br, m2r, slt, ill;
    logic [2:0]  alu;
    logic [1:0]  bop;
  } exp_t;

  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0;
  exp_t        m_e = '0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  // Instruction semantics as listed in the ISA: funct3 table, then the two funct7 variants.
  function automatic exp_t m_decode(input logic [31:0] ins);
    exp_t       e;
    logic [2:0] f3;
    logic [2:0] base [8];
    base = '{3'd0, 3'd5, 3'd1, 3'd1, 3'd4, 3'd6, 3'd3, 3'd2};
    e = '0;
    f3 = ins[14:12];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.r1  = m_read(e.rs1);
    e.r2  = m_read(e.rs2);
    case (ins[6:0])
      7'h33, 7'h13: begin
        e.regw   = 1'b1;
        e.alusrc = (ins[6:0] == 7'h13);
        e.alu    = base[f3];
        if (f3 == 3'd0 && ins[30] && ins[6:0] == 7'h33) e.alu = 3'd1;
        if (f3 == 3'd5 && ins[30]) e.alu = 3'd7;
        e.slt    = (f3 == 3'd2) || (f3 == 3'd3);
        if (e.alusrc) e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'h03: begin
        e.regw = 1'b1; e.alusrc = 1'b1; e.memr = 1'b1; e.m2r = 1'b1;
        e.imm  = {{20{ins[31]}}, ins[31:20]};
      end
      7'h23: begin
        e.memw = 1'b1; e.alusrc = 1'b1;
        e.imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        e.br  = 1'b1; e.alu = 3'd1;
        e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        case (f3)
          3'd1, 3'd3: e.bop = 2'd1;
          3'd4, 3'd6: e.bop = 2'd2;
          3'd5, 3'd7: e.bop = 2'd3;
          default:    e.bop = 2'd0;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic m_haz();
    logic [31:0] ins;
    logic        needs2;
    ins    = bus.i_instruccion;
    needs2 = ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63;
    return m_valid && m_e.memr && m_e.rd != 0 &&
           (m_e.rd == ins[19:15] || (needs2 && m_e.rd == ins[24:20]));
  endfunction

  function automatic logic m_ready();
    return rst_n && !m_haz() && (!m_valid || bus.i_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
    end else begin
      if (wb_en && wb_addr != 0) m_rf[wb_addr] <= wb_data;
      if (flush)                                m_valid <= 1'b0;
      else if (m_valid && !bus.i_ready)         m_valid <= m_valid;
      else if (bus.i_valid && m_ready()) begin
        m_valid <= 1'b1;
        m_e     <= m_decode(bus.i_instruccion);
      end else                                  m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
      chk("o_ready", 32'(bus.o_ready), 32'(m_ready()));
      if (m_valid) begin
        chk("o_register1", bus.o_register1, m_e.r1);
        chk("o_register2", bus.o_register2, m_e.r2);
        chk("o_constante", bus.o_constante, m_e.imm);
        chk("addr", {17'd0, bus.o_rs1, bus.o_rs2, bus.o_WriteReg}, {17'd0, m_e.rs1, m_e.rs2, m_e.rd});
        chk("ctrl", {19'd0, bus.o_RegWrite, bus.o_ALUSrc, bus.o_MemWrite, bus.o_MemRead,
                     bus.o_Branch, bus.o_MemToReg, bus.o_SLTc, bus.o_illegal,
                     bus.o_ALUControl, bus.o_BranchOp},
                    {19'd0, m_e.regw, m_e.alusrc, m_e.memw, m_e.memr, m_e.br, m_e.m2r,
                     m_e.slt, m_e.ill, m_e.alu, m_e.bop});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD3  = 32'h002101B3; // add x3,x2,x2
  localparam logic [31:0] I_LW    = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] I_OR    = 32'h0020E3B3; // or x7,x1,x2
  localparam logic [31:0] I_XOR   = 32'h0020C433; // xor x8,x1,x2
  localparam logic [31:0] I_BEQ   = 32'h00208463; // beq x1,x2,+8
  localparam logic [31:0] I_SUB   = 32'h402084B3; // sub x9,x1,x2
  localparam logic [31:0] I_SLTI  = 32'hFFF0A213; // slti x4,x1,-1
  localparam logic [31:0] I_SW    = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] I_ADD00 = 32'h000001B3; // add x3,x0,x0

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_instruccion = 32'h00000013;
    tick();
    started = 1'b1;
    tick();
    chk("reset o_ready", 32'(bus.o_ready), 32'd0);
    chk("reset o_valid", 32'(bus.o_valid), 32'd0);
    chk("reset o_constante", bus.o_constante, 32'd0);

    rst_n = 1'b1; bus.i_valid = 1'b1; bus.i_instruccion = I_ADDI;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    tick();
    chk("addi valid", 32'(bus.o_valid), 32'd1);
    chk("addi imm", bus.o_constante, 32'd5);
    chk("addi ctl", {29'd0, bus.o_ALUSrc, bus.o_RegWrite, bus.o_MemRead}, 32'b110);
    chk("addi alu/rd", {24'd0, bus.o_ALUControl, bus.o_WriteReg}, {24'd0, 3'b000, 5'd1});

    bus.i_instruccion = I_ADD3; wb_addr = 5'd2; wb_data = 32'hDEADBEEF;
    tick();
`ifdef ID_WB_BYPASS_EN
    chk("same-cycle wb rs1", bus.o_register1, 32'hDEADBEEF);
`else
    chk("same-cycle wb rs1", bus.o_register1, 32'd0);
`endif
    wb_en = 1'b0;

    bus.i_instruccion = I_LW;
    tick();
    chk("lw memread", 32'(bus.o_MemRead), 32'd1);
    bus.i_instruccion = I_ADD6;
    #1 chk("load-use ready", 32'(bus.o_ready), 32'd0);
    tick();
    chk("bubble valid", 32'(bus.o_valid), 32'd0);
    chk("after bubble ready", 32'(bus.o_ready), 32'd1);
    tick();
    chk("add after stall rd", 32'(bus.o_WriteReg), 32'd6);

    bus.i_instruccion = I_OR;
    tick();
    chk("or operands", bus.o_register2, 32'hDEADBEEF);
    bus.i_ready = 1'b0; bus.i_instruccion = I_XOR;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall held rd", 32'(bus.o_WriteReg), 32'd7);
      chk("stall ready", 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    tick();
    chk("release advances", {27'd0, bus.o_ALUControl, bus.o_WriteReg[1:0]}, {27'd0, 3'b100, 2'd0});

    bus.i_instruccion = I_BEQ;
    tick();
    chk("beq imm", bus.o_constante, 32'd8);
    chk("beq ctl", {27'd0, bus.o_Branch, bus.o_RegWrite, bus.o_ALUControl}, {27'd0, 1'b1, 1'b0, 3'b001});
    bus.i_instruccion = I_SUB; flush = 1'b1;
    tick();
    chk("flush kills", 32'(bus.o_valid), 32'd0);
    flush = 1'b0; bus.i_valid = 1'b0;
    tick();
    chk("sub never issued", 32'(bus.o_valid), 32'd0);

    bus.i_valid = 1'b1; bus.i_instruccion = I_BEQ;
    tick();
    bus.i_ready = 1'b0; bus.i_instruccion = I_SUB; flush = 1'b1;
    tick();
    chk("flush beats stall", 32'(bus.o_valid), 32'd0);
    flush = 1'b0; bus.i_ready = 1'b1;

    bus.i_instruccion = 32'h0000007F;
    tick();
    chk("illegal", {28'd0, bus.o_illegal, bus.o_RegWrite, bus.o_MemWrite, bus.o_Branch}, 32'b1000);
    bus.i_instruccion = I_SLTI;
    tick();
    chk("slti imm", bus.o_constante, 32'hFFFFFFFF);
    chk("slti ctl", {28'd0, bus.o_SLTc, bus.o_ALUControl}, {28'd0, 1'b1, 3'b001});
    bus.i_instruccion = I_SW;
    tick();
    chk("sw imm", bus.o_constante, 32'hFFFFFFFC);
    chk("sw ctl", {30'd0, bus.o_MemWrite, bus.o_RegWrite}, 32'b10);

    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; bus.i_instruccion = I_ADDI;
    tick();
    wb_en = 1'b0; bus.i_instruccion = I_ADD00;
    tick();
    chk("x0 stays zero", bus.o_register1, 32'd0);

    bus.i_instruccion = I_OR;
    tick();
    bus.i_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("reset mid-stall valid", 32'(bus.o_valid), 32'd0);
    chk("reset mid-stall ready", 32'(bus.o_ready), 32'd0);
    rst_n = 1'b1; bus.i_ready = 1'b1;
    tick();
    chk("rf cleared x1", bus.o_register1, 32'd0);
    chk("rf cleared x2", bus.o_register2, 32'd0);

    bus.i_valid = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_stage_piped.md
# id_stage_piped

Parametrised RISC-V decode stage with an internal register file and a registered ID/EX pipeline boundary. Accepts one instruction per cycle from fetch over a valid/ready handshake and decodes it into operands, a sign-extended immediate and control bits. Detects load-use hazards against the instruction it holds and inserts bubbles, and honours a branch flush. Sits between the fetch stage and the execute stage of the pipelined core.

## Interface
- `WIDTH`, 32, datapath and register width (≥32)
- `NREGS`, 32, architectural register count (power of two, 2..32); `RA = $clog2(NREGS)`
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  synchronous active-low reset
- `i_valid`  in  1  fetch presents `i_instruccion`
- `o_ready`  out  1  stage accepts instruction this cycle
- `i_instruccion`  in  32  RV32I encoding
- `i_flush`  in  1  branch taken in EX: kill held and incoming instruction
- `i_RegWrite`  in  1  writeback enable
- `i_WriteReg`  in  RA  writeback address
- `i_WriteData`  in  WIDTH  writeback data
- `o_valid`  out  1  ID/EX register holds a real instruction
- `i_ready`  in  1  execute accepts ID/EX contents
- `o_register1`, `o_register2`  out  WIDTH  rs1/rs2 operand values
- `o_constante`  out  WIDTH  sign-extended immediate
- `o_rs1`, `o_rs2`, `o_WriteReg`  out  RA  source/destination addresses (for forwarding)
- `o_RegWrite`, `o_ALUSrc`, `o_MemWrite`, `o_MemRead`, `o_Branch`, `o_MemToReg`, `o_SLTc`, `o_illegal`  out  1 each  control
- `o_ALUControl`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA
- `o_BranchOp`  out  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE

## Operation
- Register file: NREGS×WIDTH; x0 reads 0, writes to x0 ignored; write on posedge when `i_RegWrite`; all entries cleared by reset.
- Decode by opcode: R 0110011 (ALUSrc=0), I-ALU 0010011, load 0000011 (MemRead, MemToReg), store 0100011 (MemWrite, RegWrite=0), branch 1100011 (Branch, ALU SUB, RegWrite=0). Any other opcode: all control 0, `o_illegal`=1.
- ALU: funct3/funct7[5] select op; SUB only for R-type funct7[5]=1; SLT/SLTI → ALU SUB with `o_SLTc`=1. Loads/stores → ADD.
- Immediate: I-type inst[31:20], S-type {inst[31:25],inst[11:7]}, B-type {inst[31],inst[7],inst[30:25],inst[11:8],0}; sign-extended to WIDTH; R-type 0.
- Register addresses truncated to RA bits when NREGS<32.
- Hazard: `haz` = `o_valid & o_MemRead & o_WriteReg≠0 & (o_WriteReg==rs1 | (o_WriteReg==rs2 & opcode uses rs2))`; rs2 used by R, store, branch.
- `o_ready` = `i_rst_n & ~haz & (~o_valid | i_ready)`.
- ID/EX load (`adv` = `~o_valid | i_ready`): if `i_flush` → `o_valid`←0; else if `haz` → bubble (`o_valid`←0, control bits 0); else if `i_valid & o_ready` → capture decode, `o_valid`←1; else `o_valid`←0.
- Flush: incoming instruction is consumed (`o_ready` as above) and discarded; flush wins over hazard and over `i_ready`=0.

## Timing
- Reset: every output register 0, `o_valid`=0, `o_ready`=0 while `i_rst_n`=0.
- Latency 1 cycle: instruction accepted at edge N appears on outputs after edge N.
- Stalled (`o_valid & ~i_ready`, no flush): all outputs held stable.
- Load-use: exactly one bubble cycle, then the stalled instruction is accepted.
- Reset mid-stall or mid-flush: reset takes precedence; register file contents lost.

## Configuration
- `ID_WB_BYPASS_EN` defined: when `i_RegWrite` and `i_WriteReg` (≠0) equals rs1/rs2 in the capture cycle, the captured operand is `i_WriteData` (write-through).
- Undefined: captured operand is the pre-write register content; execute forwarding covers the case.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with `i_ready`=1 → next cycle `o_valid`=1, `o_constante`=5, ALUSrc=1, RegWrite=1, ALU 000, rd=1.
- Write x2=0xDEADBEEF, same cycle capture `add x3,x2,x2` → `o_register1`=0xDEADBEEF with macro, 0 without.
- `lw x5,0(x1)` then `add x6,x5,x0` → one cycle `o_ready`=0 and `o_valid`=0 bubble, add issued next cycle.
- Hold `i_ready`=0 three cycles with valid output → outputs unchanged, `o_ready`=0; release → advances.
- `i_flush`=1 while `beq` held and `sub` incoming → next cycle `o_valid`=0, sub never issued.
- Opcode 0x7F → `o_illegal`=1, RegWrite/MemWrite/Branch=0; `slti x4,x1,-1` → `o_constante`=0xFFFFFFFF, `o_SLTc`=1, ALU 001.
